// File: rtl/memory_access_controller_if.sv
// memory_access_controller_if
//   Bundles the core-side request/response handshakes and the external
//   single-port memory bus used by memory_access_controller.
//   master : the controller's view (drives bus strobes, done pulses, stall)
//   slave  : the environment's view (core stages and memory model)
//   Signals:
//     fetch_req/fetch_addr -> fetch_data/fetch_done     instruction fetch
//     read_mem/write_mem/load_byte/store_byte,
//     data_addr/data_wdata -> data_rdata/data_done      load/store
//     stall                                             pipeline freeze
//     bus_addr/bus_wdata/bus_be/bus_ren/bus_wen,
//     bus_rdata/bus_ack                                 memory bus
interface memory_access_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_done;
    logic              read_mem;
    logic              write_mem;
    logic              load_byte;
    logic              store_byte;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_done;
    logic              stall;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_be;
    logic              bus_ren;
    logic              bus_wen;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        input  fetch_req, fetch_addr, read_mem, write_mem, load_byte,
               store_byte, data_addr, data_wdata, bus_rdata, bus_ack,
        output fetch_data, fetch_done, data_rdata, data_done, stall,
               bus_addr, bus_wdata, bus_be, bus_ren, bus_wen
    );

    modport slave (
        output fetch_req, fetch_addr, read_mem, write_mem, load_byte,
               store_byte, data_addr, data_wdata, bus_rdata, bus_ack,
        input  fetch_data, fetch_done, data_rdata, data_done, stall,
               bus_addr, bus_wdata, bus_be, bus_ren, bus_wen
    );
endinterface

// File: rtl/memory_access_controller.sv
// memory_access_controller
//   Arbitrates instruction fetch and data load/store onto one shared
//   single-port memory bus. Data wins over fetch, store wins over load.
//   Handles sb/lb byte lanes and holds the pipeline stalled until the
//   access completes.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     mif  - memory_access_controller_if.master (requests, responses, bus)
module memory_access_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    memory_access_controller_if.master mif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              bus_ren_q, bus_ren_d;
    logic              bus_wen_q, bus_wen_d;
    logic              is_lb_q, is_lb_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              fetch_done_q, fetch_done_d;
    logic              data_done_q, data_done_d;
    logic              stall_s;

    // Select byte lane k (bits 8k+7:8k) of a read word and sign-extend it.
    function automatic logic [DATA_W-1:0] lb_extend(input logic [DATA_W-1:0] word,
                                                     input logic [1:0]        lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

    // State and output register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= 4'h0;
            bus_ren_q    <= 1'b0;
            bus_wen_q    <= 1'b0;
            is_lb_q      <= 1'b0;
            lane_q       <= 2'd0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            bus_ren_q    <= bus_ren_d;
            bus_wen_q    <= bus_wen_d;
            is_lb_q      <= is_lb_d;
            lane_q       <= lane_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
            fetch_done_q <= fetch_done_d;
            data_done_q  <= data_done_d;
        end
    end

    // Next-state and next-output logic; bus fields hold while waiting for ack.
    always_comb begin
        state_d      = state_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        bus_ren_d    = bus_ren_q;
        bus_wen_d    = bus_wen_q;
        is_lb_d      = is_lb_q;
        lane_d       = lane_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;
        fetch_done_d = 1'b0;
        data_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mif.write_mem) begin
                    state_d    = DATA;
                    bus_addr_d = {mif.data_addr[ADDR_W-1:2], 2'b00};
                    bus_ren_d  = 1'b0;
                    bus_wen_d  = 1'b1;
                    is_lb_d    = 1'b0;
                    lane_d     = mif.data_addr[1:0];
                    if (mif.store_byte) begin
                        bus_be_d    = 4'b0001 << mif.data_addr[1:0];
                        bus_wdata_d = {4{mif.data_wdata[7:0]}};
                    end else begin
                        bus_be_d    = 4'hF;
                        bus_wdata_d = mif.data_wdata;
                    end
                end else if (mif.read_mem) begin
                    state_d     = DATA;
                    bus_addr_d  = {mif.data_addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = mif.data_wdata;
                    bus_be_d    = 4'hF;
                    bus_ren_d   = 1'b1;
                    bus_wen_d   = 1'b0;
                    is_lb_d     = mif.load_byte;
                    lane_d      = mif.data_addr[1:0];
                end else if (mif.fetch_req) begin
                    state_d    = FETCH;
                    bus_addr_d = {mif.fetch_addr[ADDR_W-1:2], 2'b00};
                    bus_be_d   = 4'hF;
                    bus_ren_d  = 1'b1;
                    bus_wen_d  = 1'b0;
                    is_lb_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (mif.bus_ack) begin
                    state_d     = RESP;
                    bus_ren_d   = 1'b0;
                    bus_wen_d   = 1'b0;
                    data_done_d = 1'b1;
                    // A store leaves the previous load result untouched.
                    if (bus_wen_q) begin
                        data_rdata_d = data_rdata_q;
                    end else if (is_lb_q) begin
                        data_rdata_d = lb_extend(mif.bus_rdata, lane_q);
                    end else begin
                        data_rdata_d = mif.bus_rdata;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            FETCH: begin
                if (mif.bus_ack) begin
                    state_d      = RESP;
                    bus_ren_d    = 1'b0;
                    bus_wen_d    = 1'b0;
                    fetch_done_d = 1'b1;
                    fetch_data_d = mif.bus_rdata;
                end else begin
                    state_d = FETCH;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                bus_ren_d = 1'b0;
                bus_wen_d = 1'b0;
            end
        endcase
    end

    // Stall rises in the same cycle a request is seen so the PC freezes at once.
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            IDLE:    stall_s = mif.read_mem | mif.write_mem | mif.fetch_req;
            DATA:    stall_s = 1'b1;
            FETCH:   stall_s = 1'b1;
            RESP:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    assign mif.bus_addr   = bus_addr_q;
    assign mif.bus_wdata  = bus_wdata_q;
    assign mif.bus_be     = bus_be_q;
    assign mif.bus_ren    = bus_ren_q;
    assign mif.bus_wen    = bus_wen_q;
    assign mif.fetch_data = fetch_data_q;
    assign mif.fetch_done = fetch_done_q;
    assign mif.data_rdata = data_rdata_q;
    assign mif.data_done  = data_done_q;
    assign mif.stall      = stall_s;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed testbench for memory_access_controller: hand-written sequences for
// reset, fetch latency, arbitration and reset mid-access, plus a table of
// load/store vectors with hand-computed bus fields and load results.
module tb_memory_access_controller;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    memory_access_controller_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    memory_access_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .mif (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic        byte_op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus_if.fetch_req  = 1'b0;
        bus_if.fetch_addr = 32'h0;
        bus_if.read_mem   = 1'b0;
        bus_if.write_mem  = 1'b0;
        bus_if.load_byte  = 1'b0;
        bus_if.store_byte = 1'b0;
        bus_if.data_addr  = 32'h0;
        bus_if.data_wdata = 32'h0;
        bus_if.bus_rdata  = 32'h0;
        bus_if.bus_ack    = 1'b0;
    endtask

    initial begin
        logic [31:0] last_load;
        vec_t v;
        checks   = 0;
        failures = 0;

        //             wr    rd    byte  addr          wdata         rdata         exp_addr      be     exp_wdata     exp_rdata
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0203, 32'h1234_56AB, 32'h0,        32'h0000_0200, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0207, 32'hCAFE_F00D, 32'h0,        32'h0000_0204, 4'hF,    32'hCAFE_F00D, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0302, 32'h0,         32'h1180_7F00, 32'h0000_0300, 4'hF,    32'h0,         32'hFFFF_FF80};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0301, 32'h0,         32'h1180_7F00, 32'h0000_0300, 4'hF,    32'h0,         32'h0000_007F};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_030B, 32'h0,         32'h89AB_CDEF, 32'h0000_0308, 4'hF,    32'h0,         32'h89AB_CDEF};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_00FF, 32'h0,        32'h0000_0100, 4'b0001, 32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_0303, 32'h0,         32'h1180_7F00, 32'h0000_0300, 4'hF,    32'h0,         32'h0000_0011};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h55AA_55AA, 32'h0,        32'h0000_0400, 4'hF,    32'h55AA_55AA, 32'h0};

        clear_inputs();
        rst = 1'b1;

        // Reset held with fetch_req high: everything registered stays zero.
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = 32'h0000_0010;
        step();
        step();
        check("rst_bus_ren", {31'h0, bus_if.bus_ren}, 32'h0);
        check("rst_bus_wen", {31'h0, bus_if.bus_wen}, 32'h0);
        check("rst_bus_addr", bus_if.bus_addr, 32'h0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
        check("rst_bus_be", {28'h0, bus_if.bus_be}, 32'h0);
        check("rst_fetch_done", {31'h0, bus_if.fetch_done}, 32'h0);
        check("rst_data_done", {31'h0, bus_if.data_done}, 32'h0);
        check("rst_fetch_data", bus_if.fetch_data, 32'h0);
        check("rst_data_rdata", bus_if.data_rdata, 32'h0);

        // First cycle out of reset samples the fetch.
        rst = 1'b0;
        step();
        check("fetch_ren", {31'h0, bus_if.bus_ren}, 32'h1);
        check("fetch_addr", bus_if.bus_addr, 32'h0000_0010);
        check("fetch_be", {28'h0, bus_if.bus_be}, 32'hF);
        // Three wait cycles without ack.
        for (int i = 0; i < 3; i++) begin
            step();
            check("fetch_wait_stall", {31'h0, bus_if.stall}, 32'h1);
            check("fetch_wait_done", {31'h0, bus_if.fetch_done}, 32'h0);
            check("fetch_wait_ren", {31'h0, bus_if.bus_ren}, 32'h1);
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h0000_0093;
        step();
        check("fetch_done_pulse", {31'h0, bus_if.fetch_done}, 32'h1);
        check("fetch_no_data_done", {31'h0, bus_if.data_done}, 32'h0);
        check("fetch_data", bus_if.fetch_data, 32'h0000_0093);
        check("fetch_resp_stall", {31'h0, bus_if.stall}, 32'h0);
        check("fetch_resp_ren", {31'h0, bus_if.bus_ren}, 32'h0);
        bus_if.fetch_req = 1'b0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        step();
        check("fetch_done_once", {31'h0, bus_if.fetch_done}, 32'h0);
        check("idle_stall", {31'h0, bus_if.stall}, 32'h0);
        check("fetch_data_hold", bus_if.fetch_data, 32'h0000_0093);

        // Fetch and load together: data goes first.
        bus_if.fetch_req  = 1'b1;
        bus_if.fetch_addr = 32'h0000_0200;
        bus_if.read_mem   = 1'b1;
        bus_if.data_addr  = 32'h0000_0104;
        #1;
        check("arb_idle_stall", {31'h0, bus_if.stall}, 32'h1);
        step();
        check("arb_data_addr", bus_if.bus_addr, 32'h0000_0104);
        check("arb_data_ren", {31'h0, bus_if.bus_ren}, 32'h1);
        check("arb_data_wen", {31'h0, bus_if.bus_wen}, 32'h0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hDEAD_BEEF;
        step();
        check("arb_data_done", {31'h0, bus_if.data_done}, 32'h1);
        check("arb_no_fetch_done", {31'h0, bus_if.fetch_done}, 32'h0);
        check("arb_lw_rdata", bus_if.data_rdata, 32'hDEAD_BEEF);
        last_load = 32'hDEAD_BEEF;
        bus_if.read_mem = 1'b0;
        bus_if.bus_ack  = 1'b0;
        step();
        check("arb_idle_ren", {31'h0, bus_if.bus_ren}, 32'h0);
        check("arb_idle_stall2", {31'h0, bus_if.stall}, 32'h1);
        step();
        check("arb_fetch_addr", bus_if.bus_addr, 32'h0000_0200);
        check("arb_fetch_ren", {31'h0, bus_if.bus_ren}, 32'h1);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h0000_0013;
        step();
        check("arb_fetch_done", {31'h0, bus_if.fetch_done}, 32'h1);
        check("arb_fetch_data", bus_if.fetch_data, 32'h0000_0013);
        check("arb_rdata_hold", bus_if.data_rdata, 32'hDEAD_BEEF);
        bus_if.fetch_req = 1'b0;
        bus_if.bus_ack   = 1'b0;
        step();

        // Table of load/store vectors, one wait cycle each.
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            bus_if.write_mem  = v.wr;
            bus_if.read_mem   = v.rd;
            bus_if.store_byte = v.byte_op & v.wr;
            bus_if.load_byte  = v.byte_op & ~v.wr;
            bus_if.data_addr  = v.addr;
            bus_if.data_wdata = v.wdata;
            step();
            check($sformatf("vec%0d_addr", i), bus_if.bus_addr, v.exp_addr);
            check($sformatf("vec%0d_be", i), {28'h0, bus_if.bus_be}, {28'h0, v.exp_be});
            check($sformatf("vec%0d_wen", i), {31'h0, bus_if.bus_wen}, {31'h0, v.wr});
            check($sformatf("vec%0d_ren", i), {31'h0, bus_if.bus_ren}, {31'h0, ~v.wr});
            if (v.wr) begin
                check($sformatf("vec%0d_wdata", i), bus_if.bus_wdata, v.exp_wdata);
            end else begin
                check($sformatf("vec%0d_wdata_na", i), 32'h0, 32'h0 & bus_if.bus_wdata);
            end
            step();
            check($sformatf("vec%0d_wait_stall", i), {31'h0, bus_if.stall}, 32'h1);
            check($sformatf("vec%0d_wait_addr", i), bus_if.bus_addr, v.exp_addr);
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = v.rdata;
            step();
            check($sformatf("vec%0d_done", i), {31'h0, bus_if.data_done}, 32'h1);
            if (!v.wr) begin
                last_load = v.exp_rdata;
            end
            check($sformatf("vec%0d_rdata", i), bus_if.data_rdata, last_load);
            check($sformatf("vec%0d_strobes_low", i),
                  {30'h0, bus_if.bus_ren, bus_if.bus_wen}, 32'h0);
            clear_inputs();
            step();
            check($sformatf("vec%0d_done_once", i), {31'h0, bus_if.data_done}, 32'h0);
        end

        // Ack while idle is ignored.
        bus_if.bus_ack = 1'b1;
        step();
        check("idle_ack_done", {30'h0, bus_if.data_done, bus_if.fetch_done}, 32'h0);
        bus_if.bus_ack = 1'b0;

        // Reset while waiting for a load ack.
        bus_if.read_mem  = 1'b1;
        bus_if.data_addr = 32'h0000_0500;
        step();
        check("rmid_ren", {31'h0, bus_if.bus_ren}, 32'h1);
        rst = 1'b1;
        step();
        check("rmid_ren_low", {31'h0, bus_if.bus_ren}, 32'h0);
        check("rmid_no_done", {31'h0, bus_if.data_done}, 32'h0);
        rst = 1'b0;
        bus_if.read_mem  = 1'b0;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h7777_7777;
        step();
        check("rmid_ack_no_done", {31'h0, bus_if.data_done}, 32'h0);
        check("rmid_idle_stall", {31'h0, bus_if.stall}, 32'h0);
        check("rmid_rdata_cleared", bus_if.data_rdata, 32'h0);
        bus_if.bus_ack = 1'b0;
        step();
        check("rmid_still_idle", {30'h0, bus_if.bus_ren, bus_if.data_done}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_controller.md
# memory_access_controller

Sequences all memory traffic for the rv32 core over one shared single-port memory bus. Arbitrates between instruction fetch and the data access requested by the control logic unit (read_mem/write_mem, load_byte/store_byte), drives byte lanes for sb/lb, and stalls the pipeline until the access completes. Sits between the fetch/decode/execute stages and the external memory bus.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte-lane logic fixed for 32)

- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  instruction fetch request, held until fetch_done
- fetch_addr  in  ADDR_W  fetch address (PC)
- fetch_data  out  DATA_W  fetched instruction, valid when fetch_done
- fetch_done  out  1  one-cycle completion pulse
- read_mem  in  1  data load request from control logic
- write_mem  in  1  data store request from control logic
- load_byte  in  1  lb when high, lw when low
- store_byte  in  1  sb when high, sw when low
- data_addr  in  ADDR_W  ALU-computed effective address
- data_wdata  in  DATA_W  store data (rs2)
- data_rdata  out  DATA_W  load result, valid when data_done
- data_done  out  1  one-cycle completion pulse
- stall  out  1  freeze PC and pipeline registers
- bus_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
- bus_wdata  out  DATA_W  write data
- bus_be  out  4  byte enables
- bus_ren  out  1  read strobe
- bus_wen  out  1  write strobe
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  access complete

## Operation
- FSM states: IDLE, DATA, FETCH, RESP.
- IDLE: if write_mem -> latch store, go DATA; else if read_mem -> latch load, go DATA; else if fetch_req -> latch fetch, go FETCH; else stay.
- Priority: data over fetch; write_mem over read_mem if both high (illegal combo, write wins deterministically).
- DATA/FETCH: bus_addr, bus_wdata, bus_be, bus_ren/bus_wen held constant from latched values until bus_ack; on bus_ack capture result, go RESP.
- RESP: exactly one cycle; pulses data_done or fetch_done (never both); all requests ignored; -> IDLE.
- Requesters must deassert or change request the cycle after done; a request still high in IDLE is a new access.
- Store lanes: sw -> bus_be=4'hF, bus_wdata=data_wdata; sb -> bus_be=4'b0001<<addr[1:0], bus_wdata={4{data_wdata[7:0]}}. Fetch and loads -> bus_be=4'hF.
- Load data: lw -> data_rdata=bus_rdata; lb -> sign-extend bus_rdata byte lane addr[1:0] (lane k = bits 8k+7:8k).
- addr[1:0] ignored for sw/lw/fetch (no misalignment trap).
- stall = (IDLE and (read_mem|write_mem|fetch_req)) | DATA | FETCH; low in RESP.
- bus_ack in IDLE or RESP ignored.

## Timing
- Reset: state IDLE; fetch_data, data_rdata = 0; fetch_done, data_done, bus_ren, bus_wen = 0; bus_addr, bus_wdata = 0; bus_be = 0.
- Request sampled in IDLE cycle N; strobes registered, high from N+1.
- bus_ack in cycle M (M >= N+1) -> RESP and done pulse in M+1, strobes low in M+1; min latency request->done = 2 cycles.
- Back-to-back: next access strobes earliest M+3 (RESP, IDLE sample).
- fetch_data/data_rdata registered on ack, hold until next completion of same kind.
- Reset mid-access: next edge -> IDLE, strobes drop, no done pulse, pending ack discarded.
- No timeout: absent bus_ack, controller waits indefinitely with stall high.

## Test plan
- Reset with fetch_req high -> all outputs 0 during rst; first cycle after -> bus_ren=1, bus_addr=fetch_addr, bus_be=4'hF.
- Fetch 0x0000_0010, bus_ack after 3 wait cycles with rdata 0x0000_0093 -> fetch_done one cycle, fetch_data=0x0000_0093, stall low only in RESP.
- fetch_req and read_mem same cycle, lw addr 0x104 -> data access first, bus_addr=0x104; fetch issued after data_done.
- sb data_wdata=0x1234_56AB addr 0x203 -> bus_be=4'b1000, bus_wdata=0xABAB_ABAB, bus_wen=1, bus_ren=0.
- lb addr 0x302, bus_rdata=0x1180_7F00 -> data_rdata=0xFFFF_FF80; lb addr 0x301 same data -> 0x0000_007F.
- Assert rst while in DATA waiting for ack, then ack -> no data_done, strobes low, state IDLE.
